// File: rtl/mux2to1v.sv
`default_nettype none
// ============================================================================
// mux2to1v : WIDTH-bit 2:1 mux with combinational and registered outputs,
//            plus select-toggle strobe and saturating toggle counter.
// Rev 1.0
// ============================================================================
module mux2to1v #(
  parameter int WIDTH = 100,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_toggle,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_toggle;
  logic w_cnt_sat;

  // Ternary keeps X/Z on the unselected input from reaching the output.
  assign out       = sel ? b : a;
  assign w_toggle  = (sel != sel_q);
  assign w_cnt_sat = &toggle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      sel_q      <= 1'b0;
      sel_toggle <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      out_q      <= out;
      sel_q      <= sel;
      sel_toggle <= w_toggle;
      if (w_toggle && !w_cnt_sat)
        toggle_cnt <= toggle_cnt + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux2to1v.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mux2to1v : directed self-checking bench for mux2to1v.
// Rev 1.0
// ============================================================================
module tb_mux2to1v;

  localparam int WIDTH = 100;
  localparam int CNT_W = 8;   // small counter keeps the saturation run short
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             sel;
  logic [WIDTH-1:0] out, out_q;
  logic             sel_q, sel_toggle;
  logic [CNT_W-1:0] toggle_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] pat_a, pat_b, ra, rb, exp_v;
  logic [127:0]     tmp;
  logic [CNT_W-1:0] exp_cnt;

  mux2to1v #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .out        (out),
    .out_q      (out_q),
    .sel_q      (sel_q),
    .sel_toggle (sel_toggle),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; sel = 1'b0;
    tick(); tick();
    check("rst_out_q", 128'(out_q), 128'd0);
    check("rst_sel_q", 128'(sel_q), 128'd0);
    check("rst_toggle", 128'(sel_toggle), 128'd0);
    check("rst_cnt", 128'(toggle_cnt), 128'd0);
    rst_n = 1'b1;

    // zeros on both inputs, first edge after reset with sel=1 counts
    #1 check("zero_sel0", 128'(out), 128'd0);
    sel = 1'b1;
    #1 check("zero_sel1", 128'(out), 128'd0);
    tick();
    check("zero_out_q", 128'(out_q), 128'd0);
    check("first_sel_q", 128'(sel_q), 128'd1);
    check("first_toggle", 128'(sel_toggle), 128'd1);
    check("first_cnt", 128'(toggle_cnt), 128'd1);

    // single-bit patterns
    a = 100'd1; b = '0; sel = 1'b0;
    #1 check("one_a", 128'(out), 128'd1);
    tick();
    check("one_a_q", 128'(out_q), 128'd1);
    check("one_a_cnt", 128'(toggle_cnt), 128'd2);
    a = '0; b = 100'd1; sel = 1'b1;
    #1 check("one_b", 128'(out), 128'd1);
    tick();
    check("one_b_cnt", 128'(toggle_cnt), 128'd3);

    // alternating patterns exercise every lane including bit 99
    pat_a = {25{4'hA}};
    pat_b = {25{4'h5}};
    a = pat_a; b = pat_b; sel = 1'b0;
    #1 check("alt_a", 128'(out), 128'(pat_a));
    check("alt_a_b99", 128'(out[99]), 128'd1);
    tick();
    check("alt_a_q", 128'(out_q), 128'(pat_a));
    sel = 1'b1;
    #1 check("alt_b", 128'(out), 128'(pat_b));
    check("alt_b_b99", 128'(out[99]), 128'd0);
    tick();
    check("alt_b_q", 128'(out_q), 128'(pat_b));
    check("alt_cnt", 128'(toggle_cnt), 128'd5);

    // half-width patterns; unselected input must not matter (incl. X)
    pat_a = {{50{1'b1}}, {50{1'b0}}};
    pat_b = {{50{1'b0}}, {50{1'b1}}};
    a = pat_a; b = pat_b; sel = 1'b0;
    #1 check("half_a", 128'(out), 128'(pat_a));
    b = 'x;
    #1 check("half_a_bx", 128'(out), 128'(pat_a));
    b = pat_b;
    tick();
    check("half_cnt6", 128'(toggle_cnt), 128'd6);
    sel = 1'b1;
    #1 check("half_b", 128'(out), 128'(pat_b));
    a = 'x;
    #1 check("half_b_ax", 128'(out), 128'(pat_b));
    a = pat_a;
    tick();
    check("half_b_q", 128'(out_q), 128'(pat_b));
    tick();
    check("steady_toggle", 128'(sel_toggle), 128'd0);
    check("steady_cnt", 128'(toggle_cnt), 128'd7);

    // async reset mid-cycle while registers are nonzero
    sel = 1'b0;
    tick();
    check("pre_rst_toggle", 128'(sel_toggle), 128'd1);
    check("pre_rst_cnt", 128'(toggle_cnt), 128'd8);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_q", 128'(out_q), 128'd0);
    check("async_sel_q", 128'(sel_q), 128'd0);
    check("async_toggle", 128'(sel_toggle), 128'd0);
    check("async_cnt", 128'(toggle_cnt), 128'd0);
    check("rst_out_live", 128'(out), 128'(pat_a));

    // counter must stay cleared while reset is held and sel toggles
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      sel = ~sel;
      tick();
    end
    check("hold_cnt", 128'(toggle_cnt), 128'd0);
    check("hold_out_q", 128'(out_q), 128'd0);
    check("hold_sel_q", 128'(sel_q), 128'd0);

    // random data held constant, 10 toggles
    tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
    ra  = tmp[WIDTH-1:0];
    tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
    rb  = tmp[WIDTH-1:0];
    a = ra; b = rb; sel = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_cnt", 128'(toggle_cnt), 128'd0);
    check("rel_out_q", 128'(out_q), 128'(ra));
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      sel = ~sel;
      exp_v = sel ? rb : ra;
      #1 check("rnd_out", 128'(out), 128'(exp_v));
      check("rnd_out_q_lag", 128'(out_q), 128'(sel ? ra : rb));
      tick();
      exp_cnt = exp_cnt + 1'b1;
      check("rnd_out_q", 128'(out_q), 128'(exp_v));
      check("rnd_toggle", 128'(sel_toggle), 128'd1);
      check("rnd_cnt", 128'(toggle_cnt), 128'(exp_cnt));
    end
    check("rnd_cnt10", 128'(toggle_cnt), 128'd10);
    tick();
    check("rnd_no_toggle", 128'(sel_toggle), 128'd0);

    // saturation: 2^CNT_W + 5 toggles in total since release
    for (int i = 0; i < (1 << CNT_W) - 1 - 10 - 1; i++) begin
      sel = ~sel;
      tick();
    end
    check("sat_below", 128'(toggle_cnt), 128'(C_CNT_MAX - 1'b1));
    for (int i = 0; i < 7; i++) begin
      sel = ~sel;
      tick();
    end
    check("sat_max", 128'(toggle_cnt), 128'(C_CNT_MAX));
    check("sat_toggle", 128'(sel_toggle), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
